// File: rtl/music_pkg.sv
// Shared types and constants for the music sequencer: FSM states, song ROM entry
// layout and a default demo song used when no song image is supplied.
package music_pkg;

    localparam int PITCH_W = 6;
    localparam int DUR_W   = 4;
    localparam logic [PITCH_W-1:0] PITCH_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [DUR_W-1:0]   dur;
    } song_entry_t;

    localparam int ENTRY_W      = $bits(song_entry_t);
    localparam int MAX_SONG_LEN = 64;

    // Entry i sits at bits [i*ENTRY_W +: ENTRY_W]; a rising 8-note figure of eighth notes.
    function automatic logic [MAX_SONG_LEN*ENTRY_W-1:0] scale_song();
        logic [MAX_SONG_LEN*ENTRY_W-1:0] s;
        s = '0;
        for (int i = 0; i < MAX_SONG_LEN; i++) begin
            s[i*ENTRY_W +: ENTRY_W] = {PITCH_W'(20 + (i % 8)), DUR_W'(2)};
        end
        return s;
    endfunction

endpackage

// File: rtl/music_song_rom.sv
// Synchronous-read song ROM: the entry at addr appears on data one clock later.
module music_song_rom
    import music_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int ADDR_W   = $clog2(SONG_LEN),
    parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output song_entry_t       data
);

    song_entry_t mem [SONG_LEN];
    song_entry_t data_d;
    song_entry_t data_q;

    for (genvar i = 0; i < SONG_LEN; i++) begin : g_mem
        assign mem[i] = song_entry_t'(SONG_INIT[i*ENTRY_W +: ENTRY_W]);
    end

    always_comb begin
        data_d = '0;
        if (int'(addr) < SONG_LEN) begin
            data_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/music_note_sequencer.sv
// Song sequencer: walks the song ROM at a tempo set by a tick divider and drives the
// square-wave tone generator, plus note_start/beat strobes for the VGA visualiser.
module music_note_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV   = 390625,
    parameter int STEP_TICKS = 8,
    parameter int GAP_TICKS  = 1,
    parameter int BEAT_STEPS = 4,
    parameter int SONG_LEN   = 32,
    parameter int ADDR_W     = $clog2(SONG_LEN),
    parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_INIT = (SONG_LEN*ENTRY_W)'(scale_song())
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play,
    input  logic               restart,
    input  logic               loop_en,
    output logic [PITCH_W-1:0] pitch,
    output logic               sound_en,
    output logic               note_start,
    output logic               beat,
    output logic [ADDR_W-1:0]  note_addr,
    output logic               busy,
    output logic               done
);

    localparam int BEAT_TICKS = BEAT_STEPS * STEP_TICKS;
    localparam int DIV_W      = $clog2(TICK_DIV);
    localparam int REM_W      = $clog2(((1 << DUR_W) - 1) * STEP_TICKS + 1);
    localparam int BEAT_W     = $clog2(BEAT_TICKS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PITCH_W-1:0] pitch_q, pitch_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic               sound_en_q, sound_en_d;
    logic               note_start_q, note_start_d;
    logic               beat_q, beat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick;
    logic               song_end;
    song_entry_t        rom_data;

    // The ROM is addressed with the next address so its data is valid during the FETCH cycle.
    music_song_rom #(
        .SONG_LEN  (SONG_LEN),
        .ADDR_W    (ADDR_W),
        .SONG_INIT (SONG_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (addr_d),
        .data (rom_data)
    );

    assign tick = !restart && (state_q == ST_PLAY) && play && (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            pitch_q      <= PITCH_REST;
            rem_q        <= '0;
            div_q        <= '0;
            beat_cnt_q   <= '0;
            sound_en_q   <= 1'b0;
            note_start_q <= 1'b0;
            beat_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pitch_q      <= pitch_d;
            rem_q        <= rem_d;
            div_q        <= div_d;
            beat_cnt_q   <= beat_cnt_d;
            sound_en_q   <= sound_en_d;
            note_start_q <= note_start_d;
            beat_q       <= beat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pitch_d    = pitch_q;
        rem_d      = rem_q;
        div_d      = div_q;
        beat_cnt_d = beat_cnt_q;
        song_end   = 1'b0;
        if (restart) begin
            state_d    = ST_FETCH;
            addr_d     = '0;
            rem_d      = '0;
            div_d      = '0;
            beat_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A fresh song start lines the beat grid up with entry 0.
                    if (play) begin
                        state_d    = ST_FETCH;
                        addr_d     = '0;
                        rem_d      = '0;
                        div_d      = '0;
                        beat_cnt_d = '0;
                    end
                end
                ST_FETCH: begin
                    if (rom_data.dur == '0) begin
                        song_end = 1'b1;
                    end else begin
                        pitch_d = rom_data.pitch;
                        rem_d   = REM_W'(rom_data.dur) * REM_W'(STEP_TICKS);
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (play) begin
                        div_d = tick ? '0 : div_q + 1'b1;
                        if (tick) begin
                            rem_d      = rem_q - 1'b1;
                            beat_cnt_d = (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
                            if (rem_q == REM_W'(1)) begin
                                if (addr_q == LAST_ADDR) begin
                                    song_end = 1'b1;
                                end else begin
                                    addr_d  = addr_q + 1'b1;
                                    state_d = ST_FETCH;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!play) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
            if (song_end) begin
                if (loop_en) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                end else begin
                    state_d = ST_DONE;
                    pitch_d = PITCH_REST;
                end
            end
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        sound_en_d   = (state_d == ST_PLAY) && play && (pitch_d != PITCH_REST)
                       && (rem_d > REM_W'(GAP_TICKS));
        note_start_d = (state_q == ST_FETCH) && (state_d == ST_PLAY);
        beat_d       = tick && (beat_cnt_q == BEAT_LAST);
        busy_d       = (state_d == ST_FETCH) || (state_d == ST_PLAY);
        done_d       = (state_d == ST_DONE);
    end

    assign pitch      = pitch_q;
    assign sound_en   = sound_en_q;
    assign note_start = note_start_q;
    assign beat       = beat_q;
    assign note_addr  = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
